// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

    localparam int BAUD_DIV_DFLT  = 2604;
    localparam int RCV_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rcv_state_t;

endpackage

// File: rtl/uart_rcv_if.sv
// Receiver-side link bundle: serial line, consumer handshake and error flags.
interface uart_rcv_if;

    logic       i_rx;
    logic       i_clr_rdy;
    logic [7:0] o_rx_data;
    logic       o_rdy;
    logic       o_frm_err;
    logic       o_ovr_err;

    modport master (
        output i_rx, i_clr_rdy,
        input  o_rx_data, o_rdy, o_frm_err, o_ovr_err
    );

    modport slave (
        input  i_rx, i_clr_rdy,
        output o_rx_data, o_rdy, o_frm_err, o_ovr_err
    );

endinterface

// File: rtl/uart_rcv_fifo.sv
// Small first-word-fall-through byte FIFO (DEPTH must be a power of two).
module uart_rcv_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = RCV_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_dout  = r_mem[r_rptr];

    // A full FIFO still accepts a push when the head is popped the same cycle.
    assign w_wr = i_push & (~o_full | i_pop);
    assign w_rd = i_pop & ~o_empty;

    // NOTE: storage carries no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver with rdy/clr_rdy handshake, framing and overrun flags.
// Define UART_RCV_FIFO_EN to place a 4-entry FIFO between deserialiser and outputs.
module uart_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
    input logic       clk,
    input logic       rst_n,
    uart_rcv_if.slave rcv
);

    localparam logic [12:0] L_BIT_CNT  = 13'(BAUD_DIV);
    localparam logic [12:0] L_HALF_CNT = 13'(BAUD_DIV / 2);

    rcv_state_t  r_state;
    rcv_state_t  w_state_nxt;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic [12:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [8:0]  r_shift;
    logic        r_done;
    logic        r_ovr_err;
    logic        w_fall;
    logic        w_baud_exp;
    logic        w_start_load;
    logic        w_sample;
    logic        w_frame_end;
    logic        w_deliver;

    // Preset high so a reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a true three-stage shift.
            r_rx_meta <= rcv.i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_baud_exp = (r_baud_cnt == 13'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
        w_state_nxt  = r_state;
        w_start_load = 1'b0;
        w_sample     = 1'b0;
        w_frame_end  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt  = START;
                    w_start_load = 1'b1;
                end
            end
            START: begin
                if (w_baud_exp) begin
                    w_state_nxt = r_rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_baud_exp) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_baud_exp) begin
                    w_sample    = 1'b1;
                    w_frame_end = 1'b1;
                    w_state_nxt = r_rx_sync ? IDLE : BRK;
                end
            end
            BRK: begin
                if (r_rx_sync) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reload on expiry keeps bit timing free of cumulative drift; parked when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_start_load) begin
                r_baud_cnt <= L_HALF_CNT;
                r_bit_cnt  <= '0;
            end else if (w_state_nxt == IDLE || w_state_nxt == BRK) begin
                r_baud_cnt <= '0;
            end else if (w_baud_exp) begin
                r_baud_cnt <= L_BIT_CNT;
            end else if (r_baud_cnt != '0) begin
                r_baud_cnt <= r_baud_cnt - 13'd1;
            end
            if (w_sample) begin
                r_shift <= {r_rx_sync, r_shift[8:1]};
                if (r_state == DATA) begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    // r_shift[8] holds the stop bit once the frame has ended.
    assign w_deliver     = r_done & r_shift[8];
    assign rcv.o_frm_err = r_done & ~r_shift[8];
    assign rcv.o_ovr_err = r_ovr_err;

`ifdef UART_RCV_FIFO_EN
    logic [7:0] w_head;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;

    assign w_pop = rcv.i_clr_rdy & ~w_empty;

    uart_rcv_fifo #(
        .DEPTH (RCV_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_deliver),
        .i_pop   (w_pop),
        .i_din   (r_shift[7:0]),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign rcv.o_rdy     = ~w_empty;
    assign rcv.o_rx_data = w_empty ? 8'h00 : w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_err <= 1'b0;
        end else if (w_deliver && w_full && !w_pop) begin
            r_ovr_err <= 1'b1;
        end else if (rcv.i_clr_rdy) begin
            r_ovr_err <= 1'b0;
        end
    end
`else
    logic [7:0] r_rx_data;
    logic       r_rdy;

    assign rcv.o_rdy     = r_rdy;
    assign rcv.o_rx_data = r_rx_data;

    // An acknowledge coinciding with delivery consumes the old byte, not the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data <= 8'h00;
            r_rdy     <= 1'b0;
            r_ovr_err <= 1'b0;
        end else if (w_deliver) begin
            r_rx_data <= r_shift[7:0];
            r_rdy     <= 1'b1;
            if (rcv.i_clr_rdy) begin
                r_ovr_err <= 1'b0;
            end else if (r_rdy) begin
                r_ovr_err <= 1'b1;
            end
        end else if (rcv.i_clr_rdy) begin
            r_rdy     <= 1'b0;
            r_ovr_err <= 1'b0;
        end
    end
`endif

endmodule
